// File: rtl/iobus_if.sv
// iobus_if: signal bundle between the two requesters (instruction fetch and
// data port), the iobus_arbiter and the shared memory port.
// The slave modport is the arbiter's view: it serves the I/D requesters and
// drives the memory port. The master modport is the opposite side, which
// owns the requesters and the memory responder.
interface iobus_if;
    // instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    // data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    // timeout flag, qualified by i_ack/d_ack
    logic        err;
    // shared memory port
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/iobus_arbiter.sv
// iobus_arbiter: shares one memory port between an instruction-fetch and a
// data requester, one access outstanding at a time, with a per-access
// watchdog that aborts a grant that never sees m_ack.
// Optional feature: define ARB_RR_EN for round-robin arbitration of
// simultaneous requests; without it the data port always wins.
module iobus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic    clk,
    input  logic    rst,
    iobus_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Watchdog value at which a grant without m_ack is abandoned.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        port_q, port_d;     // served port: 1 = data, 0 = instruction
    logic        err_q, err_d;
`ifdef ARB_RR_EN
    logic        last_q, last_d;     // last served port: 1 = data, 0 = instruction
`endif

    logic        both_pick_d;        // winner when both requests are high
    logic        grant;

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wd_q    <= 8'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            port_q  <= port_d;
            err_q   <= err_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state logic: arbitration, request latching, completion and watchdog.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        port_d  = port_q;
        err_d   = err_q;
`ifdef ARB_RR_EN
        last_d      = last_q;
        // Alternate: give the simultaneous request to whoever was not served last.
        both_pick_d = ~last_q;
`else
        both_pick_d = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (bus.d_req && (!bus.i_req || both_pick_d)) begin
                    state_d = GRANT_D;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    wd_d    = 8'd0;
                    err_d   = 1'b0;
                end else if (bus.i_req) begin
                    state_d = GRANT_I;
                    addr_d  = bus.i_addr;
                    we_d    = 1'b0;
                    wdata_d = 32'd0;
                    wd_d    = 8'd0;
                    err_d   = 1'b0;
                end
            end

            GRANT_I, GRANT_D: begin
                // A late m_ack on the timeout cycle still counts as a completion.
                if (bus.m_ack) begin
                    rdata_d = bus.m_rdata;
                    port_d  = (state_q == GRANT_D);
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WD_LIMIT) begin
                    rdata_d = 32'd0;
                    port_d  = (state_q == GRANT_D);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end

            RESP: begin
                // Requests are not looked at here, so one dropped on its ACK
                // cycle is never serviced twice.
                state_d = IDLE;
`ifdef ARB_RR_EN
                last_d  = port_q;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    assign grant = (state_q == GRANT_I) || (state_q == GRANT_D);

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        bus.m_req   = grant;
        bus.m_we    = grant ? we_q    : 1'b0;
        bus.m_addr  = grant ? addr_q  : 32'd0;
        bus.m_wdata = grant ? wdata_q : 32'd0;
        bus.i_ack   = (state_q == RESP) && !port_q;
        bus.d_ack   = (state_q == RESP) &&  port_q;
        bus.err     = (state_q == RESP) &&  err_q;
        bus.i_rdata = ((state_q == RESP) && !port_q) ? rdata_q : 32'd0;
        bus.d_rdata = ((state_q == RESP) &&  port_q) ? rdata_q : 32'd0;
    end

endmodule
